// File: rtl/coin_acceptor.sv
// coin_acceptor: coin-mechanism front end for vending_machine.
//
// Debounces the raw nickel and dime sensors, accumulates accepted coins as
// thermometer codes on N/D, refuses coins once the price is met, and runs the
// vend handshake: on R it holds the buses for HOLD_CYCLES, then clears them,
// and pulses change_nickel in the clear cycle if S was set on the R edge.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   nickel_in      raw nickel sensor (high while a coin passes)
//   dime_in        raw dime sensor (high while a coin passes)
//   R              release from vending_machine
//   S              change flag from vending_machine
//   N[4:0]         nickel thermometer code
//   D[2:0]         dime thermometer code
//   reject         one-cycle pulse: a debounced coin was refused
//   change_nickel  one-cycle pulse: dispense one nickel of change
//   busy           high while vending or clearing
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 5,
  parameter int unsigned PRICE           = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nickel_in,
  input  logic       dime_in,
  input  logic       R,
  input  logic       S,
  output logic [4:0] N,
  output logic [2:0] D,
  output logic       reject,
  output logic       change_nickel,
  output logic       busy
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [DbW-1:0]   DbMax    = DbW'(DEBOUNCE_CYCLES);
  localparam logic [DbW-1:0]   DbFire   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [5:0]       PriceC   = 6'(PRICE);

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StVend,
    StClear
  } state_e;

  state_e           state_q, state_d;
  logic [DbW-1:0]   nick_cnt_q, nick_cnt_d;
  logic [DbW-1:0]   dime_cnt_q, dime_cnt_d;
  logic [4:0]       n_q, n_d;
  logic [2:0]       d_q, d_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             s_q, s_d;
  logic             reject_q, reject_d;

  logic       nick_ev, dime_ev;
  logic       nick_ok, dime_ok;
  logic       accepting;
  logic [2:0] n_ones;
  logic [1:0] d_ones;
  logic [5:0] total, total_pd;

  // ---------------------------------------------------------------------------
  // State register (all flops)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      nick_cnt_q <= '0;
      dime_cnt_q <= '0;
      n_q        <= '0;
      d_q        <= '0;
      hold_q     <= '0;
      s_q        <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      nick_cnt_q <= nick_cnt_d;
      dime_cnt_q <= dime_cnt_d;
      n_q        <= n_d;
      d_q        <= d_d;
      hold_q     <= hold_d;
      s_q        <= s_d;
      reject_q   <= reject_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: saturating run-length counters. The event fires only on the
  // sample that brings the count to DEBOUNCE_CYCLES, so a long high period
  // still yields exactly one coin.
  // ---------------------------------------------------------------------------
  always_comb begin
    nick_cnt_d = '0;
    nick_ev    = 1'b0;
    if (nickel_in) begin
      nick_cnt_d = (nick_cnt_q == DbMax) ? nick_cnt_q : nick_cnt_q + DbW'(1);
      nick_ev    = (nick_cnt_q == DbFire);
    end
  end

  always_comb begin
    dime_cnt_d = '0;
    dime_ev    = 1'b0;
    if (dime_in) begin
      dime_cnt_d = (dime_cnt_q == DbMax) ? dime_cnt_q : dime_cnt_q + DbW'(1);
      dime_ev    = (dime_cnt_q == DbFire);
    end
  end

  // ---------------------------------------------------------------------------
  // Running total and coin acceptance. The dime is judged first; the nickel is
  // judged against the total including an accepted dime.
  // ---------------------------------------------------------------------------
  always_comb begin
    n_ones = '0;
    for (int i = 0; i < 5; i++) begin
      n_ones = n_ones + {2'b00, n_q[i]};
    end
    d_ones = '0;
    for (int i = 0; i < 3; i++) begin
      d_ones = d_ones + {1'b0, d_q[i]};
    end
  end

  always_comb begin
    total     = 6'(n_ones) * 6'd5 + 6'(d_ones) * 6'd10;
    accepting = (state_q == StIdle) || (state_q == StCollect);
    dime_ok   = dime_ev && accepting && (total < PriceC) && (d_q != 3'b111);
    total_pd  = total + (dime_ok ? 6'd10 : 6'd0);
    nick_ok   = nick_ev && accepting && (total_pd < PriceC) && (n_q != 5'b11111);
    reject_d  = (dime_ev && !dime_ok) || (nick_ev && !nick_ok);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    s_d     = s_q;
    unique case (state_q)
      StIdle: begin
        if (dime_ok || nick_ok) begin
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (R) begin
          state_d = StVend;
          hold_d  = '0;
          s_d     = S;
        end
      end
      StVend: begin
        if (hold_q == HoldLast) begin
          state_d = StClear;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StClear: begin
        state_d = StIdle;
        s_d     = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Bus update. Buses clear on the edge entering StClear, so the vending
  // machine already sees zero during the change-return cycle.
  always_comb begin
    n_d = n_q;
    d_d = d_q;
    if ((state_q == StVend) && (state_d == StClear)) begin
      n_d = '0;
      d_d = '0;
    end else begin
      if (dime_ok) begin
        d_d = {d_q[1:0], 1'b1};
      end
      if (nick_ok) begin
        n_d = {n_q[3:0], 1'b1};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    N             = n_q;
    D             = d_q;
    reject        = reject_q;
    busy          = (state_q == StVend) || (state_q == StClear);
    change_nickel = (state_q == StClear) && s_q;
  end

endmodule
